// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned HOLD_CNT_W = 4;
  localparam int unsigned STATS_W    = 8;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GX   = 2'd1,
    GY   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold-time counter; tc_c flags the last cycle a grant may be held
// while the other side waits.
module mux_arb_hold_cnt
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  localparam logic [HOLD_CNT_W-1:0] TC_VAL = HOLD_CNT_W'(HOLD - 1);

  logic [HOLD_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc_c) begin
      cnt <= cnt + HOLD_CNT_W'(1);
    end
  end

  assign tc_c = (cnt == TC_VAL);

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin scheduler with bounded hold for a shared WIDTH-bit 2:1 mux path.
// Define MUX_ARB_STATS_EN to add saturating per-requester grant-cycle counters.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_x,
  input  logic [WIDTH-1:0]     data_x,
  input  logic                 req_y,
  input  logic [WIDTH-1:0]     data_y,
  output logic                 grant_x,
  output logic                 grant_y,
  output logic                 sel,
  output logic [WIDTH-1:0]     data_out,
`ifdef MUX_ARB_STATS_EN
  output logic [STATS_W-1:0]   cnt_x,
  output logic [STATS_W-1:0]   cnt_y,
`endif
  output logic                 valid
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       last;
  logic       hold_tc_c;
  logic       enter_c;
  logic       stay_c;

  mux_arb_hold_cnt #(
    .HOLD (HOLD)
  ) u_hold_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter_c),
    .inc  (stay_c),
    .tc_c (hold_tc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: last-served side loses ties; hold expiry hands over to a waiting peer.
  always_comb begin
    state_nxt = state;
    enter_c   = 1'b0;
    stay_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req_x && req_y) begin
          state_nxt = last ? GX : GY;
        end else if (req_x) begin
          state_nxt = GX;
        end else if (req_y) begin
          state_nxt = GY;
        end
      end
      GX: begin
        if (!req_x) begin
          state_nxt = req_y ? GY : IDLE;
        end else if (req_y && hold_tc_c) begin
          state_nxt = GY;
        end
      end
      GY: begin
        if (!req_y) begin
          state_nxt = req_x ? GX : IDLE;
        end else if (req_x && hold_tc_c) begin
          state_nxt = GX;
        end
      end
      default: state_nxt = IDLE;
    endcase
    enter_c = (state_nxt != state) && (state_nxt != IDLE);
    stay_c  = (state_nxt == state);
  end

  // sel and last follow grant entries; both hold through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel  <= SEL_X;
      last <= 1'b1;
    end else if (enter_c) begin
      sel  <= (state_nxt == GY) ? SEL_Y : SEL_X;
      last <= (state_nxt == GY);
    end
  end

  assign grant_x = (state == GX);
  assign grant_y = (state == GY);
  assign valid   = grant_x | grant_y;

  always_comb begin
    data_out = '0;
    if (state == GY) begin
      data_out = data_y;
    end else if (state == GX) begin
      data_out = data_x;
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else begin
      if (grant_x && (cnt_x != {STATS_W{1'b1}})) begin
        cnt_x <= cnt_x + STATS_W'(1);
      end
      if (grant_y && (cnt_y != {STATS_W{1'b1}})) begin
        cnt_y <= cnt_y + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (HOLD=4 main instance, HOLD=1 companion).
module tb_mux_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             req_x;
  logic             req_y;
  logic [WIDTH-1:0] data_x;
  logic [WIDTH-1:0] data_y;

  logic             grant_x, grant_y, sel, valid;
  logic [WIDTH-1:0] data_out;
  logic             grant_x1, grant_y1, sel1, valid1;
  logic [WIDTH-1:0] data_out1;
`ifdef MUX_ARB_STATS_EN
  logic [7:0]       cnt_x, cnt_y, cnt_x1, cnt_y1;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mux_arbiter #(.WIDTH(WIDTH), .HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_x    (req_x),
    .data_x   (data_x),
    .req_y    (req_y),
    .data_y   (data_y),
    .grant_x  (grant_x),
    .grant_y  (grant_y),
    .sel      (sel),
    .data_out (data_out),
`ifdef MUX_ARB_STATS_EN
    .cnt_x    (cnt_x),
    .cnt_y    (cnt_y),
`endif
    .valid    (valid)
  );

  mux_arbiter #(.WIDTH(WIDTH), .HOLD(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .req_x    (req_x),
    .data_x   (data_x),
    .req_y    (req_y),
    .data_y   (data_y),
    .grant_x  (grant_x1),
    .grant_y  (grant_y1),
    .sel      (sel1),
    .data_out (data_out1),
`ifdef MUX_ARB_STATS_EN
    .cnt_x    (cnt_x1),
    .cnt_y    (cnt_y1),
`endif
    .valid    (valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grants must never overlap on either instance.
  always @(negedge clk) begin
    if (grant_x && grant_y) begin
      chk_cnt++;
      $display("FAIL excl_hold4: grant_x=%b grant_y=%b, required not both 1", grant_x, grant_y);
    end
    if (grant_x1 && grant_y1) begin
      chk_cnt++;
      $display("FAIL excl_hold1: grant_x=%b grant_y=%b, required not both 1", grant_x1, grant_y1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed observation {grant_x, grant_y, sel, valid, data_out}.
  function automatic logic [7:0] obs();
    return {grant_x, grant_y, sel, valid, data_out};
  endfunction

  function automatic logic [7:0] obs1();
    return {grant_x1, grant_y1, sel1, valid1, data_out1};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_x = 1'b0; req_y = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_x = 1'b0; req_y = 1'b0; data_x = 4'h0; data_y = 4'h0;
    step();
    step();
    chk_cnt++;
    if (obs() !== 8'b0000_0000) $display("FAIL reset_outputs: got %b required %b", obs(), 8'b0000_0000);
    else pass_cnt++;
    rst = 1'b0;
    step();
    chk_cnt++;
    if (obs() !== 8'b0000_0000) $display("FAIL reset_idle: got %b required %b", obs(), 8'b0000_0000);
    else pass_cnt++;
  endtask

  task automatic test_single();
    req_x = 1'b1; data_x = 4'hA;
    step();
    chk_cnt++;
    if (obs() !== 8'b1001_1010) $display("FAIL single_grant: got %b required %b", obs(), 8'b1001_1010);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_cnt++;
      if (obs() !== 8'b1001_1010) $display("FAIL single_hold[%0d]: got %b required %b", i, obs(), 8'b1001_1010);
      else pass_cnt++;
    end
    req_x = 1'b0;
    step();
    chk_cnt++;
    if (obs() !== 8'b0000_0000) $display("FAIL single_release: got %b required %b", obs(), 8'b0000_0000);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    do_reset();
    data_x = 4'h3; data_y = 4'hC;
    req_x = 1'b1; req_y = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp = ((i / 4) % 2 == 0) ? 8'b1001_0011 : 8'b0111_1100;
      chk_cnt++;
      if (obs() !== exp) $display("FAIL rr_hold4[%0d]: got %b required %b", i, obs(), exp);
      else pass_cnt++;
    end
`ifdef MUX_ARB_STATS_EN
    chk_cnt++;
    if ({cnt_x, cnt_y} !== {8'd7, 8'd4})
      $display("FAIL stats_count: got cnt_x=%0d cnt_y=%0d required 7 4", cnt_x, cnt_y);
    else pass_cnt++;
`endif
    req_x = 1'b0; req_y = 1'b0;
    step();
  endtask

  task automatic test_hold_one();
    logic [7:0] exp;
    do_reset();
    data_x = 4'h6; data_y = 4'h9;
    req_x = 1'b1; req_y = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp = (i % 2 == 0) ? 8'b1001_0110 : 8'b0111_1001;
      chk_cnt++;
      if (obs1() !== exp) $display("FAIL rr_hold1[%0d]: got %b required %b", i, obs1(), exp);
      else pass_cnt++;
    end
    req_x = 1'b0; req_y = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_x = 4'h2; data_y = 4'h5;
    req_x = 1'b1;
    step();
    req_y = 1'b1;
    step();
    step();
    chk_cnt++;
    if (obs() !== 8'b1001_0010) $display("FAIL b2b_x_held: got %b required %b", obs(), 8'b1001_0010);
    else pass_cnt++;
    req_x = 1'b0;
    step();
    chk_cnt++;
    if (obs() !== 8'b0111_0101) $display("FAIL b2b_switch: got %b required %b", obs(), 8'b0111_0101);
    else pass_cnt++;
    data_y = 4'hE;
    #1;
    chk_cnt++;
    if (data_out !== 4'hE) $display("FAIL b2b_data_follow: got %h required %h", data_out, 4'hE);
    else pass_cnt++;
    req_y = 1'b0;
    step();
    chk_cnt++;
    if (obs() !== 8'b0010_0000) $display("FAIL b2b_idle_sel_kept: got %b required %b", obs(), 8'b0010_0000);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_x = 4'h1; data_y = 4'h8;
    req_x = 1'b1; req_y = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_cnt++;
    if (obs() !== 8'b0111_1000) $display("FAIL mid_in_gy: got %b required %b", obs(), 8'b0111_1000);
    else pass_cnt++;
    rst = 1'b1;
    step();
    chk_cnt++;
    if (obs() !== 8'b0000_0000) $display("FAIL mid_reset: got %b required %b", obs(), 8'b0000_0000);
    else pass_cnt++;
`ifdef MUX_ARB_STATS_EN
    chk_cnt++;
    if ({cnt_x, cnt_y} !== 16'h0000)
      $display("FAIL mid_reset_stats: got cnt_x=%0d cnt_y=%0d required 0 0", cnt_x, cnt_y);
    else pass_cnt++;
`endif
    rst = 1'b0;
    step();
    chk_cnt++;
    if (obs() !== 8'b1001_0001) $display("FAIL mid_x_first: got %b required %b", obs(), 8'b1001_0001);
    else pass_cnt++;
    req_x = 1'b0; req_y = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_hold_one();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
